single_ifetch: RTL and testbench

SINGLE_IFETCH -- requirements
Module: single_ifetch

---
 rtl/single_ifetch_pkg.sv | 15 +
 rtl/single_ifetch.sv | 140 ++++++++++++++
 tb/tb_single_ifetch.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/single_ifetch_pkg.sv
// Shared CPU definitions used by the fetch stage: FSM state encoding and
// the canonical NOP instruction word.
package single_ifetch_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_REQ  = 2'd1;
    localparam logic [ST_W-1:0] ST_WAIT = 2'd2;
    localparam logic [ST_W-1:0] ST_HOLD = 2'd3;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/single_ifetch.sv
// Single-outstanding instruction fetch stage: issues one memory request at a
// time, holds the returned word for decode and counts delivered instructions.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | out of reset; capture pc_i and start fetching next cycle
// REQ   | imem_req asserted with req_pc, waiting for imem_gnt
// WAIT  | request accepted, waiting for imem_rvalid (drop_q marks flushed)
// HOLD  | instruction presented to decode until inst_ready or redirect
module single_ifetch
    import single_ifetch_pkg::*;
#(
    parameter int unsigned CNT_W           = 16,
    parameter bit          WORD_ADDR_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc_i,
    input  logic              redirect,
    output logic              pc_advance,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc,
    input  logic              inst_ready,
    output logic [CNT_W-1:0]  fetch_cnt
);

    localparam logic [31:0] ADDR_MASK = WORD_ADDR_ALIGN ? 32'hFFFF_FFFC : 32'hFFFF_FFFF;

    logic [ST_W-1:0]  state_q,      state_d;
    logic [31:0]      req_pc_q,     req_pc_d;
    logic             drop_q,       drop_d;
    logic [31:0]      inst_q,       inst_d;
    logic [31:0]      inst_pc_q,    inst_pc_d;
    logic             inst_valid_q, inst_valid_d;
    logic             pc_adv_q,     pc_adv_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;

    always_comb begin
        state_d      = state_q;
        req_pc_d     = req_pc_q;
        drop_d       = drop_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        pc_adv_d     = 1'b0;
        cnt_d        = cnt_q;

        case (state_q)
            ST_IDLE: begin
                req_pc_d = pc_i;
                state_d  = ST_REQ;
            end

            ST_REQ: begin
                if (imem_gnt) begin
                    // A redirect racing the grant still leaves one response in flight.
                    drop_d  = redirect;
                    state_d = ST_WAIT;
                end else if (redirect) begin
                    req_pc_d = pc_i;
                end
            end

            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q || redirect) begin
                        drop_d   = 1'b0;
                        req_pc_d = pc_i;
                        state_d  = ST_REQ;
                    end else begin
                        inst_d       = imem_rdata;
                        inst_pc_d    = req_pc_q;
                        inst_valid_d = 1'b1;
                        pc_adv_d     = 1'b1;
                        state_d      = ST_HOLD;
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end

            ST_HOLD: begin
                // Flush wins over a consume in the same cycle.
                if (redirect) begin
                    inst_valid_d = 1'b0;
                    req_pc_d     = pc_i;
                    state_d      = ST_REQ;
                end else if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    cnt_d        = cnt_q + CNT_W'(1);
                    req_pc_d     = pc_i;
                    state_d      = ST_REQ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            req_pc_q     <= 32'h0;
            drop_q       <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            inst_valid_q <= 1'b0;
            pc_adv_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            req_pc_q     <= req_pc_d;
            drop_q       <= drop_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            pc_adv_q     <= pc_adv_d;
            cnt_q        <= cnt_d;
        end
    end

    // req_pc_q only changes on entry to REQ or on a redirect, so the address is
    // stable for the whole request phase.
    assign imem_req   = (state_q == ST_REQ);
    assign imem_addr  = req_pc_q & ADDR_MASK;
    assign pc_advance = pc_adv_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_single_ifetch.sv
// Directed bench for single_ifetch: a default instance and a CNT_W=4 instance
// share all stimulus; expected values are hand-computed per vector.
module tb_single_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        redirect;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_ready;

    logic        pc_advance, imem_req, inst_valid;
    logic [31:0] imem_addr, inst, inst_pc;
    logic [15:0] fetch_cnt;

    logic        pc_advance4, imem_req4, inst_valid4;
    logic [31:0] imem_addr4, inst4, inst_pc4;
    logic [3:0]  fetch_cnt4;

    int checks = 0;
    int errors = 0;
    int total  = 0;
    logic [31:0] cur_pc;
    logic [31:0] held_inst;

    always #5 clk = ~clk;

    single_ifetch u_dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .redirect(redirect),
        .pc_advance(pc_advance), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .fetch_cnt(fetch_cnt)
    );

    single_ifetch #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .pc_i(pc_i), .redirect(redirect),
        .pc_advance(pc_advance4), .imem_req(imem_req4), .imem_addr(imem_addr4),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid4), .inst(inst4), .inst_pc(inst_pc4),
        .inst_ready(inst_ready), .fetch_cnt(fetch_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt();
        chk("fetch_cnt", 32'(fetch_cnt), 32'(total % 65536));
        chk("fetch_cnt4", 32'(fetch_cnt4), 32'(total % 16));
    endtask

    // Full fetch from REQ at cur_pc: grant after gdly idle cycles, rvalid two
    // cycles after the grant, consumed immediately; PC register moves by 4.
    task automatic fetch_one(input logic [31:0] data, input int gdly);
        chk("req_on", 32'(imem_req), 32'd1);
        chk("req_addr", imem_addr, cur_pc);
        for (int k = 0; k < gdly; k++) begin
            step();
            chk("req_stable", 32'(imem_req), 32'd1);
            chk("addr_stable", imem_addr, cur_pc);
        end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk("req_off_wait", 32'(imem_req), 32'd0);
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        chk("inst_valid", 32'(inst_valid), 32'd1);
        chk("inst", inst, data);
        chk("inst_pc", inst_pc, cur_pc);
        chk("pc_advance", 32'(pc_advance), 32'd1);
        pc_i       = cur_pc + 32'd4;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        total++;
        cur_pc = cur_pc + 32'd4;
        chk("pc_adv_pulse", 32'(pc_advance), 32'd0);
        chk("inst_valid_clr", 32'(inst_valid), 32'd0);
        chk("next_addr", imem_addr, cur_pc);
        chk_cnt();
    endtask

    initial begin
        rst         = 1'b0;
        pc_i        = 32'h0;
        redirect    = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        inst_ready  = 1'b0;
        step();
        step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc_adv", 32'(pc_advance), 32'd0);
        chk_cnt();

        // Basic fetch from PC 0
        rst    = 1'b1;
        cur_pc = 32'h0;
        step();
        fetch_one(32'h2008_0005, 0);

        // Redirect during REQ retargets the pending request, then a slow grant
        pc_i     = 32'h40;
        redirect = 1'b1;
        step();
        redirect = 1'b0;
        cur_pc   = 32'h40;
        pc_i     = 32'h44;
        chk("req_redirect_addr", imem_addr, 32'h40);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("slow_gnt_req", 32'(imem_req), 32'd1);
            chk("slow_gnt_addr", imem_addr, 32'h40);
        end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        step();
        imem_rvalid = 1'b0;
        chk("hold_inst", inst, 32'h0050_0093);
        chk("hold_pc", inst_pc, 32'h40);

        // Stall in HOLD for 4 cycles; a stray rvalid must not disturb it
        for (int k = 0; k < 4; k++) begin
            imem_rvalid = (k == 1);
            imem_rdata  = 32'hBAD0_0000;
            step();
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_inst", inst, 32'h0050_0093);
            chk("stall_pc", inst_pc, 32'h40);
            chk("stall_noreq", 32'(imem_req), 32'd0);
            chk("stall_noadv", 32'(pc_advance), 32'd0);
        end
        imem_rvalid = 1'b0;

        // Redirect together with inst_ready in HOLD: flush, no count
        pc_i       = 32'h200;
        redirect   = 1'b1;
        inst_ready = 1'b1;
        step();
        redirect   = 1'b0;
        inst_ready = 1'b0;
        chk("flush_valid", 32'(inst_valid), 32'd0);
        chk_cnt();
        chk("flush_addr", imem_addr, 32'h200);

        // Redirect in WAIT drops the stale response
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        pc_i     = 32'h100;
        redirect = 1'b1;
        step();
        redirect = 1'b0;
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        chk("drop_valid", 32'(inst_valid), 32'd0);
        chk("drop_adv", 32'(pc_advance), 32'd0);
        chk("drop_req", 32'(imem_req), 32'd1);
        chk("drop_addr", imem_addr, 32'h100);

        // Redirect coincident with the grant also drops
        pc_i     = 32'h300;
        imem_gnt = 1'b1;
        redirect = 1'b1;
        step();
        imem_gnt = 1'b0;
        redirect = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_0001;
        step();
        imem_rvalid = 1'b0;
        chk("gntdrop_valid", 32'(inst_valid), 32'd0);
        chk("gntdrop_addr", imem_addr, 32'h300);

        // Address alignment on an unaligned redirect target
        pc_i     = 32'h303;
        redirect = 1'b1;
        step();
        redirect = 1'b0;
        chk("align_addr", imem_addr, 32'h300);

        // Reset asserted mid-WAIT
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        rst = 1'b0;
        #1;
        total = 0;
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_valid", 32'(inst_valid), 32'd0);
        chk("arst_inst", inst, 32'h0);
        chk("arst_pc", inst_pc, 32'h0);
        chk_cnt();
        step();
        rst         = 1'b1;
        pc_i        = 32'h80;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h7777_7777;
        step();
        imem_rvalid = 1'b0;
        chk("late_rvalid_valid", 32'(inst_valid), 32'd0);
        chk("restart_addr", imem_addr, 32'h80);
        cur_pc = 32'h80;
        fetch_one(32'h0010_0113, 1);

        // Counter wrap on the 4-bit instance (total reaches 17 -> 1)
        for (int i = 0; i < 16; i++) begin
            fetch_one(32'h1000_0000 + 32'(i), i % 3);
        end
        chk("wrap4_final", 32'(fetch_cnt4), 32'd1);
        chk("cnt16_final", 32'(fetch_cnt), 32'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
